// File: rtl/addsub_seq_chunked.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// rippling the carry between chunks, with valid/ready request and result sides.
module addsub_seq_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] chunk_ext;
    logic             carry;
    logic [CHUNK:0]   chunk_full;
    logic             msb_carry_in;
    logic             accept;
    logic             last_chunk;

    // Operands shift right one chunk per cycle, so the active chunk is always
    // at the bottom; partial sum bits enter from the top of s_sh.
    always_comb begin
        chunk_full   = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry};
        chunk_ext    = WIDTH'(chunk_full[CHUNK-1:0]);
        s_next       = (s_sh >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));
        msb_carry_in = chunk_full[CHUNK-1] ^ a_sh[CHUNK-1] ^ b_sh[CHUNK-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (counter == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept     = start_valid && start_ready;
    assign last_chunk = (state == BUSY) && (counter == LAST);

    // Subtraction is A + ~B + ~borrow; visible outputs change only when the
    // final chunk completes, so partial results never leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= sub ? ~b : b;
            carry   <= sub ? ~carry_in : carry_in;
            counter <= '0;
        end else if (state == BUSY) begin
            a_sh    <= a_sh >> CHUNK;
            b_sh    <= b_sh >> CHUNK;
            s_sh    <= s_next;
            carry   <= chunk_full[CHUNK];
            counter <= counter + 1'b1;
            if (last_chunk) begin
                sum       <= s_next;
                carry_out <= chunk_full[CHUNK];
                overflow  <= msb_carry_in ^ chunk_full[CHUNK];
                zero      <= (s_next == '0);
                negative  <= s_next[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_addsub_seq_chunked.sv
// Directed bench: three instances (16/4, 16/1, 16/16) share one request stream
// so latency and results are checked against hand-computed values for each.
module tb_addsub_seq_chunked;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         sub = 1'b0;
    logic         carry_in = 1'b0;
    logic         result_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         sr4, rv4, co4, ov4, z4, n4;
    logic         sr1, rv1, co1, ov1, z1, n1;
    logic         sr16, rv16, co16, ov16, z16, n16;
    logic [W-1:0] s4, s1, s16;

    int total = 0;
    int bad = 0;
    int lat4, lat1, lat16;

    always #5 clk = ~clk;

    addsub_seq_chunked #(.WIDTH(W), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr4),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .result_valid(rv4), .result_ready(result_ready), .sum(s4),
        .carry_out(co4), .overflow(ov4), .zero(z4), .negative(n4)
    );

    addsub_seq_chunked #(.WIDTH(W), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr1),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .result_valid(rv1), .result_ready(result_ready), .sum(s1),
        .carry_out(co1), .overflow(ov1), .zero(z1), .negative(n1)
    );

    addsub_seq_chunked #(.WIDTH(W), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr16),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in),
        .result_valid(rv16), .result_ready(result_ready), .sum(s16),
        .carry_out(co16), .overflow(ov16), .zero(z16), .negative(n16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request, scrambles the inputs right after the accept edge,
    // then records how many edges each instance needs to raise result_valid.
    task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic isub, input logic icin);
        @(negedge clk);
        checkOutput("accept_ready4", 32'(sr4), 1);
        a = ia;
        b = ib;
        sub = isub;
        carry_in = icin;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = ~ia;
        b = ~ib;
        sub = ~isub;
        carry_in = ~icin;
        lat4 = 0;
        lat1 = 0;
        lat16 = 0;
        for (int i = 1; i <= 40 && (lat4 == 0 || lat1 == 0 || lat16 == 0); i++) begin
            @(posedge clk);
            #1;
            if (rv4 && lat4 == 0) lat4 = i;
            if (rv1 && lat1 == 0) lat1 = i;
            if (rv16 && lat16 == 0) lat16 = i;
        end
    endtask

    task automatic checkOp(input string tag, input logic [W-1:0] es,
                           input logic ec, input logic ev, input logic ez, input logic en);
        checkOutput({tag, "_lat4"}, lat4, 4);
        checkOutput({tag, "_lat1"}, lat1, 16);
        checkOutput({tag, "_lat16"}, lat16, 1);
        checkOutput({tag, "_sum4"}, 32'(s4), 32'(es));
        checkOutput({tag, "_sum1"}, 32'(s1), 32'(es));
        checkOutput({tag, "_sum16"}, 32'(s16), 32'(es));
        checkOutput({tag, "_flags4"}, 32'({co4, ov4, z4, n4}), 32'({ec, ev, ez, en}));
        checkOutput({tag, "_flags1"}, 32'({co1, ov1, z1, n1}), 32'({ec, ev, ez, en}));
        checkOutput({tag, "_flags16"}, 32'({co16, ov16, z16, n16}), 32'({ec, ev, ez, en}));
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        checkOutput("hs_ready4", 32'(sr4), 1);
        checkOutput("hs_valid4", 32'(rv4), 0);
        checkOutput("hs_ready1", 32'(sr1), 1);
        checkOutput("hs_ready16", 32'(sr16), 1);
    endtask

    initial begin
        #12;
        checkOutput("rst_ready4", 32'(sr4), 1);
        checkOutput("rst_valid4", 32'(rv4), 0);
        checkOutput("rst_sum4", 32'(s4), 0);
        checkOutput("rst_flags4", 32'({co4, ov4, z4, n4}), 0);
        checkOutput("rst_ready16", 32'(sr16), 1);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        checkOp("add_basic", 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        handshake();
        checkOutput("held_sum4", 32'(s4), 32'h5555);

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checkOp("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        handshake();

        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        checkOp("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        handshake();

        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
        checkOp("add_negovf", 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        handshake();

        applyStimulus(16'h00FF, 16'h0F00, 1'b0, 1'b1);
        checkOp("add_cin", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        handshake();

        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b0);
        checkOp("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        handshake();

        applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0);
        checkOp("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        handshake();

        applyStimulus(16'h0010, 16'h0001, 1'b1, 1'b1);
        checkOp("sub_borrow", 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0);
        handshake();

        $display("[TB] backpressure phase");
        applyStimulus(16'hA5A5, 16'h1111, 1'b0, 1'b0);
        checkOp("bp_op", 16'hB6B6, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            checkOutput("bp_sum4", 32'(s4), 32'hB6B6);
            checkOutput("bp_flags4", 32'({co4, ov4, z4, n4}), 32'b0001);
            checkOutput("bp_ready4", 32'(sr4), 0);
            checkOutput("bp_valid4", 32'(rv4), 1);
        end
        start_valid = 1'b0;
        handshake();
        checkOutput("bp_held_sum4", 32'(s4), 32'hB6B6);
        applyStimulus(16'h0003, 16'h0004, 1'b1, 1'b0);
        checkOp("bp_next", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        handshake();

        $display("[TB] reset mid-operation phase");
        @(negedge clk);
        a = 16'h1234;
        b = 16'h1111;
        sub = 1'b0;
        carry_in = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_sum4", 32'(s4), 0);
        checkOutput("mid_rst_flags4", 32'({co4, ov4, z4, n4}), 0);
        checkOutput("mid_rst_valid4", 32'(rv4), 0);
        checkOutput("mid_rst_ready4", 32'(sr4), 1);
        checkOutput("mid_rst_sum16", 32'(s16), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
        checkOp("post_rst", 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
